// File: rtl/dsp_mac_array.sv
// dsp_mac_array: LANES-wide signed multiply-accumulate over framed beats, 3-stage pipeline plus result register
// Ports: CLK rising edge; RST async active-high; CLR sync abort.
//   IN_VALID/IN_READY/IN_LAST beat handshake carrying packed OP1, OP2 and BIAS (BIAS used on a frame's first beat).
//   OUT_VALID/OUT_READY result handshake carrying packed OUT, FRAME_LEN (beats in frame) and OVF (per-lane overflow).
// Build option: DSP_MAC_SATURATE_EN clamps accumulators and reports sticky per-lane overflow; otherwise wrap, OVF=0.
module dsp_mac_array #(
    parameter int WIDTH_OP1 = 18,
    parameter int WIDTH_OP2 = 18,
    parameter int WIDTH_OUT = 48,
    parameter int LANES     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       IN_LAST,
    input  logic [LANES*WIDTH_OP1-1:0] OP1,
    input  logic [LANES*WIDTH_OP2-1:0] OP2,
    input  logic [LANES*WIDTH_OUT-1:0] BIAS,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [LANES*WIDTH_OUT-1:0] OUT,
    output logic [CNT_W-1:0]           FRAME_LEN,
    output logic [LANES-1:0]           OVF
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state_q, state_d;
    logic adv, in_fire, s3_fire, out_fire, start, in_open;
    logic s1_v, s1_last, s1_first, s2_v, s2_last, s2_first, s3_v, s3_last;
    logic [LANES*WIDTH_OP1-1:0] s1_op1;
    logic [LANES*WIDTH_OP2-1:0] s1_op2;
    logic [LANES*WIDTH_OUT-1:0] s1_bias, s2_bias, prod, s2_prod, acc_d, acc_all;
    logic [LANES-1:0] ovf_d, ovf_all;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;
    assign in_fire  = IN_VALID && adv;
    assign s3_fire  = s2_v && adv;
    assign out_fire = s3_v && s3_last && adv;
    // The input-side first flag and the S3 FSM agree; either marks a frame start.
    assign start    = (state_q == IDLE) || s2_first;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            in_open <= 1'b0;
        else if (CLR)
            in_open <= 1'b0;
        else if (in_fire)
            in_open <= !IN_LAST;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_bias  <= '0;
            s2_v     <= 1'b0;
            s2_last  <= 1'b0;
            s2_first <= 1'b0;
            s2_bias  <= '0;
            s2_prod  <= '0;
            s3_v     <= 1'b0;
            s3_last  <= 1'b0;
        end else if (CLR) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else if (adv) begin
            s1_v     <= IN_VALID;
            s1_last  <= IN_LAST;
            s1_first <= !in_open;
            s1_op1   <= OP1;
            s1_op2   <= OP2;
            s1_bias  <= BIAS;
            s2_v     <= s1_v;
            s2_last  <= s1_last;
            s2_first <= s1_first;
            s2_bias  <= s1_bias;
            s2_prod  <= prod;
            s3_v     <= s2_v;
            s3_last  <= s2_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH_OP1+WIDTH_OP2-1:0] p;
        logic signed [WIDTH_OUT-1:0] pe, sp, base, acc_q;
        assign p    = $signed(s1_op1[i*WIDTH_OP1 +: WIDTH_OP1]) * $signed(s1_op2[i*WIDTH_OP2 +: WIDTH_OP2]);
        assign pe   = p;
        assign prod[i*WIDTH_OUT +: WIDTH_OUT] = pe;
        assign sp   = s2_prod[i*WIDTH_OUT +: WIDTH_OUT];
        assign base = start ? $signed(s2_bias[i*WIDTH_OUT +: WIDTH_OUT]) : acc_q;
`ifdef DSP_MAC_SATURATE_EN
        logic signed [WIDTH_OUT:0] sum;
        logic signed [WIDTH_OUT-1:0] maxv;
        logic hit, ovf_q;
        assign sum  = base + sp;
        assign maxv = {1'b0, {(WIDTH_OUT-1){1'b1}}};
        // One guard bit: disagreement with the result sign means the true sum left the range.
        assign hit  = sum[WIDTH_OUT] != sum[WIDTH_OUT-1];
        assign acc_d[i*WIDTH_OUT +: WIDTH_OUT] = hit ? (sum[WIDTH_OUT] ? ~maxv : maxv) : sum[WIDTH_OUT-1:0];
        assign ovf_d[i] = hit || (!start && ovf_q);
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                ovf_q <= 1'b0;
            else if (CLR)
                ovf_q <= 1'b0;
            else if (s3_fire)
                ovf_q <= ovf_d[i];
        end
        assign ovf_all[i] = ovf_q;
`else
        assign acc_d[i*WIDTH_OUT +: WIDTH_OUT] = base + sp;
        assign ovf_d[i]   = 1'b0;
        assign ovf_all[i] = 1'b0;
`endif
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                acc_q <= '0;
            else if (CLR)
                acc_q <= '0;
            else if (s3_fire)
                acc_q <= acc_d[i*WIDTH_OUT +: WIDTH_OUT];
        end
        assign acc_all[i*WIDTH_OUT +: WIDTH_OUT] = acc_q;
    end

    assign cnt_d = start ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));

    always_comb begin
        state_d = state_q;
        if (s3_fire)
            state_d = s2_last ? IDLE : ACCUM;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (s3_fire)
                cnt_q <= cnt_d;
        end
    end

    // Result register: a new frame result may replace one being consumed in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            FRAME_LEN <= '0;
            OVF       <= '0;
        end else if (CLR) begin
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            FRAME_LEN <= '0;
            OVF       <= '0;
        end else if (out_fire) begin
            OUT_VALID <= 1'b1;
            OUT       <= acc_all;
            FRAME_LEN <= cnt_q;
            OVF       <= ovf_all;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end
endmodule
